// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending register writes and flags RAW/WAW hazards at issue.
module reg_scoreboard #(
    parameter int ADDRESS_LEN  = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_LEN      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   issue_reg_write,
    input  logic [ADDRESS_LEN-1:0] issue_rd_addr,
    input  logic [ADDRESS_LEN-1:0] issue_rs1_addr,
    input  logic [ADDRESS_LEN-1:0] issue_rs2_addr,
    input  logic                   wb_valid,
    input  logic [ADDRESS_LEN-1:0] wb_addr,
    input  logic                   flush,
    output logic                   stall,
    output logic [CNT_LEN-1:0]     inflight_count,
    output logic                   wb_error
);
    localparam int NREG = 2**ADDRESS_LEN;
    localparam logic [CNT_LEN-1:0] MAX_CNT = CNT_LEN'(MAX_INFLIGHT);
    logic [NREG-1:0]    pending_q, pending_d, set_mask, clr_mask;
    logic [CNT_LEN-1:0] count_q, count_d;
    logic               wb_error_q, wb_error_d;
    logic               tracked, set_w, wb_hit, wb_miss;
    // A tracked write can never target a pending rd (WAW stall), so set and clear never collide.
    always_comb begin
        tracked     = issue_reg_write && issue_rd_addr != '0;
        stall       = issue_valid && ((issue_rs1_addr != '0 && pending_q[issue_rs1_addr]) ||
                                      (issue_rs2_addr != '0 && pending_q[issue_rs2_addr]) ||
                                      (tracked && pending_q[issue_rd_addr]));
        issue_ready = !stall && !flush && !(tracked && count_q == MAX_CNT);
        set_w       = issue_valid && issue_ready && tracked;
        wb_hit      = wb_valid && wb_addr != '0 && pending_q[wb_addr];
        wb_miss     = wb_valid && wb_addr != '0 && !pending_q[wb_addr];
        set_mask    = set_w ? NREG'(1) << issue_rd_addr : '0;
        clr_mask    = wb_hit ? NREG'(1) << wb_addr : '0;
        pending_d   = flush ? '0 : (pending_q | set_mask) & ~clr_mask;
        pending_d[0] = 1'b0;
        count_d     = flush ? '0 : count_q + CNT_LEN'(set_w) - CNT_LEN'(wb_hit);
        wb_error_d  = wb_error_q || (wb_miss && !flush);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            count_q    <= '0;
            wb_error_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            wb_error_q <= wb_error_d;
        end
    end
    assign inflight_count = count_q;
    assign wb_error       = wb_error_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid, issue_ready, issue_reg_write;
    logic [4:0] issue_rd_addr, issue_rs1_addr, issue_rs2_addr;
    logic       wb_valid, flush, stall, wb_error;
    logic [4:0] wb_addr;
    logic [2:0] inflight_count;

    typedef struct {
        string      name;
        logic       st;
        logic       rdy;
        logic [2:0] cnt;
        logic       err;
    } exp_t;
    exp_t exp_q[$];
    int total = 0;
    int passed = 0;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_reg_write(issue_reg_write), .issue_rd_addr(issue_rd_addr),
        .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall(stall), .inflight_count(inflight_count), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    endtask

    // Monitor: outputs are sampled mid-cycle, after inputs settled at posedge+1.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "stall", int'(stall), int'(e.st));
            chk(e.name, "issue_ready", int'(issue_ready), int'(e.rdy));
            chk(e.name, "inflight_count", int'(inflight_count), int'(e.cnt));
            chk(e.name, "wb_error", int'(wb_error), int'(e.err));
        end
    end

    task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic wbv, input logic [4:0] wba, input logic fl);
        issue_valid = v; issue_reg_write = wr; issue_rd_addr = rd;
        issue_rs1_addr = rs1; issue_rs2_addr = rs2;
        wb_valid = wbv; wb_addr = wba; flush = fl;
    endtask

    task automatic expect_out(input string name, input logic st, input logic rdy,
                              input logic [2:0] cnt, input logic err);
        exp_t e;
        e.name = name; e.st = st; e.rdy = rdy; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        expect_out("reset", 0, 1, 0, 0);
        tick(); rst_n = 1'b1;
        // RAW on rd=5, released the cycle after writeback
        drive(1, 1, 5, 0, 0, 0, 0, 0); expect_out("iss5", 0, 1, 0, 0);
        tick(); drive(1, 0, 0, 5, 0, 0, 0, 0); expect_out("raw5", 1, 0, 1, 0);
        tick(); drive(1, 0, 0, 5, 0, 1, 5, 0); expect_out("raw5_wb_nobypass", 1, 0, 1, 0);
        tick(); drive(1, 0, 0, 5, 0, 0, 0, 0); expect_out("raw5_release", 0, 1, 0, 0);
        // fill to MAX_INFLIGHT
        tick(); drive(1, 1, 1, 0, 0, 0, 0, 0); expect_out("fill1", 0, 1, 0, 0);
        tick(); drive(1, 1, 2, 0, 0, 0, 0, 0); expect_out("fill2", 0, 1, 1, 0);
        tick(); drive(1, 1, 3, 0, 0, 0, 0, 0); expect_out("fill3", 0, 1, 2, 0);
        tick(); drive(1, 1, 4, 0, 0, 0, 0, 0); expect_out("fill4", 0, 1, 3, 0);
        tick(); drive(1, 1, 6, 0, 0, 0, 0, 0); expect_out("full", 0, 0, 4, 0);
        tick(); drive(1, 1, 6, 0, 0, 1, 1, 0); expect_out("full_wb1", 0, 0, 4, 0);
        tick(); drive(1, 1, 6, 0, 0, 0, 0, 0); expect_out("accept6", 0, 1, 3, 0);
        tick(); drive(0, 0, 0, 0, 0, 1, 2, 0); expect_out("full_again_wb2", 0, 1, 4, 0);
        // pending {3,4,6}: same-cycle issue rd=7 and writeback rd=3
        tick(); drive(1, 1, 7, 0, 0, 1, 3, 0); expect_out("iss7_wb3", 0, 1, 3, 0);
        tick(); drive(1, 0, 0, 7, 0, 0, 0, 0); expect_out("p7_set", 1, 0, 3, 0);
        tick(); drive(1, 0, 0, 3, 0, 0, 0, 0); expect_out("p3_clear", 0, 1, 3, 0);
        tick(); drive(1, 0, 0, 0, 7, 0, 0, 0); expect_out("rs2_7", 1, 0, 3, 0);
        // zero addresses and non-writing issues never stall or count
        tick(); drive(1, 1, 0, 0, 0, 0, 0, 0); expect_out("rd0", 0, 1, 3, 0);
        tick(); drive(1, 0, 4, 0, 0, 0, 0, 0); expect_out("nowrite_rd4", 0, 1, 3, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("cnt_kept", 0, 1, 3, 0);
        // spurious writeback
        tick(); drive(0, 0, 0, 0, 0, 1, 9, 0); expect_out("wb9", 0, 1, 3, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("wb_err_set", 0, 1, 3, 1);
        tick(); expect_out("wb_err_sticky", 0, 1, 3, 1);
        // flush with three outstanding {4,6,7}
        tick(); drive(1, 1, 8, 0, 0, 0, 0, 1); expect_out("flush", 0, 0, 3, 1);
        tick(); drive(1, 0, 0, 4, 6, 0, 0, 0); expect_out("post_flush", 0, 1, 0, 1);
        tick(); drive(1, 1, 7, 7, 4, 0, 0, 0); expect_out("iss7", 0, 1, 0, 1);
        tick(); drive(1, 1, 7, 0, 0, 0, 0, 0); expect_out("waw7", 1, 0, 1, 1);
        // asynchronous reset mid-operation
        tick(); drive(1, 0, 0, 7, 0, 0, 0, 0); rst_n = 1'b0; expect_out("rst_async", 0, 1, 0, 0);
        tick(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 1, 0, 0); expect_out("wb0", 0, 1, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("wb0_no_err", 0, 1, 0, 0);
        tick();
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
